// File: rtl/dm_abstract_cmd.sv
// Debug-module abstract command engine for Access Register commands.
// Decodes and validates commands from the DMI side, runs one GPR debug
// port access, keeps the result in data0 and reports busy/cmderr.
module dm_abstract_cmd #(
  parameter logic [15:0] GPR_BASE = 16'h1000,
  parameter int          NUM_GPR  = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  input  logic [31:0] cmd_i,
  input  logic        autoexec_i,
  input  logic        data0_wr_en_i,
  input  logic [31:0] data0_wdata_i,
  output logic [31:0] data0_o,
  input  logic [2:0]  cmderr_clr_i,
  input  logic        halted_i,
  output logic        busy_o,
  output logic [2:0]  cmderr_o,
  output logic        dm_reg_rd_wr_en_o,
  output logic        dm_reg_rd_wr_o,
  output logic [15:0] dm_reg_rd_wr_address_o,
  inout  wire  [31:0] dm_reg_rd_wr_data_io,
  output logic        DSP_reg_access_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_BUSY  = 3'd1;
  localparam logic [2:0] ERR_NOSUP = 3'd2;
  localparam logic [2:0] ERR_HALT  = 3'd4;

  state_e      state_q;
  logic        busy_q;
  logic [2:0]  cmderr_q, cmderr_d;
  logic [31:0] data0_q;
  logic [31:0] cmd_q;
  logic        en_q;
  logic        rw_q;
  logic [15:0] addr_q;
  logic        dsp_q;
  logic        drive_q;

  // Command as seen in the strobe cycle: a fresh write overrides the stored one.
  logic [31:0] cmd_sel;
  logic [7:0]  f_cmdtype;
  logic [2:0]  f_aarsize;
  logic        f_postexec;
  logic        f_transfer;
  logic [15:0] f_regno;
  logic        unused_aamvirtual;

  assign cmd_sel           = cmd_valid_i ? cmd_i : cmd_q;
  assign f_cmdtype         = cmd_sel[31:24];
  assign unused_aamvirtual = cmd_sel[23];
  assign f_aarsize         = cmd_sel[22:20];
  assign f_postexec        = cmd_sel[18];
  assign f_transfer        = cmd_sel[17];
  assign f_regno           = cmd_sel[15:0];

  // Range check done in 17 bits so GPR_BASE+NUM_GPR cannot wrap.
  logic [16:0] regno_ext, range_lo, range_hi;
  logic        regno_ok;
  logic        illegal;

  assign regno_ext = {1'b0, f_regno};
  assign range_lo  = {1'b0, GPR_BASE};
  assign range_hi  = range_lo + 17'(NUM_GPR);
  assign regno_ok  = (regno_ext >= range_lo) && (regno_ext < range_hi);
  assign illegal   = (f_cmdtype != 8'd0) || f_postexec ||
                     (f_transfer && ((f_aarsize != 3'd2) || !regno_ok));

  logic       strobe;
  logic       accept;
  logic       store;
  logic [2:0] new_err;
  logic [2:0] cmderr_masked;

  assign strobe        = cmd_valid_i | autoexec_i;
  assign cmderr_masked = cmderr_q & ~cmderr_clr_i;

  // Strobe-cycle checks in priority order and sticky cmderr update.
  always_comb begin
    new_err = ERR_NONE;
    accept  = 1'b0;
    store   = 1'b0;
    if (busy_q) begin
      if (strobe || data0_wr_en_i) new_err = ERR_BUSY;
    end else if (strobe && (cmderr_q == ERR_NONE)) begin
      store = cmd_valid_i;
      if (illegal)        new_err = ERR_NOSUP;
      else if (!halted_i) new_err = ERR_HALT;
      else                accept  = 1'b1;
    end
    cmderr_d = ((new_err != ERR_NONE) && (cmderr_masked == ERR_NONE)) ?
               new_err : cmderr_masked;
  end

  // Command FSM with registered port outputs, data0 and stored command.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      cmderr_q <= ERR_NONE;
      data0_q  <= 32'd0;
      cmd_q    <= 32'd0;
      en_q     <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= 16'd0;
      dsp_q    <= 1'b0;
      drive_q  <= 1'b0;
    end else begin
      cmderr_q <= cmderr_d;
      en_q     <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= 16'd0;
      dsp_q    <= 1'b0;
      drive_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (data0_wr_en_i) data0_q <= data0_wdata_i;
          if (store)         cmd_q   <= cmd_i;
          if (accept) begin
            busy_q <= 1'b1;
            if (f_transfer) begin
              state_q <= ACCESS;
              en_q    <= 1'b1;
              dsp_q   <= 1'b1;
              rw_q    <= cmd_sel[16];
              addr_q  <= f_regno;
              drive_q <= cmd_sel[16];
            end else begin
              state_q <= DONE;
            end
          end
        end
        ACCESS: begin
          if (!rw_q) data0_q <= dm_reg_rd_wr_data_io;
          state_q <= DONE;
        end
        DONE: begin
          if (cmd_q[19]) cmd_q[15:0] <= cmd_q[15:0] + 16'd1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dm_reg_rd_wr_data_io   = drive_q ? data0_q : 32'bz;
  assign data0_o                = data0_q;
  assign busy_o                 = busy_q;
  assign cmderr_o               = cmderr_q;
  assign dm_reg_rd_wr_en_o      = en_q;
  assign dm_reg_rd_wr_o         = rw_q;
  assign dm_reg_rd_wr_address_o = addr_q;
  assign DSP_reg_access_o       = dsp_q;

endmodule

// File: tb/tb_dm_abstract_cmd.sv
// Bench for dm_abstract_cmd: directed scenarios plus randomized traffic,
// GPR file model on the debug bus, access scoreboard and status checks.
module tb_dm_abstract_cmd;

  localparam logic [15:0] BASE = 16'h1000;
  localparam int          NGPR = 32;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic [31:0] cmd_i = 32'd0;
  logic        autoexec_i = 1'b0;
  logic        data0_wr_en_i = 1'b0;
  logic [31:0] data0_wdata_i = 32'd0;
  logic [31:0] data0_o;
  logic [2:0]  cmderr_clr_i = 3'd0;
  logic        halted_i = 1'b1;
  logic        busy_o;
  logic [2:0]  cmderr_o;
  logic        en;
  logic        rw;
  logic [15:0] addr;
  wire  [31:0] bus;
  logic        dsp;

  always #5 clk = ~clk;

  dm_abstract_cmd #(.GPR_BASE(BASE), .NUM_GPR(NGPR)) dut (
    .clk_i(clk), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_i(cmd_i),
    .autoexec_i(autoexec_i), .data0_wr_en_i(data0_wr_en_i),
    .data0_wdata_i(data0_wdata_i), .data0_o(data0_o),
    .cmderr_clr_i(cmderr_clr_i), .halted_i(halted_i), .busy_o(busy_o),
    .cmderr_o(cmderr_o), .dm_reg_rd_wr_en_o(en), .dm_reg_rd_wr_o(rw),
    .dm_reg_rd_wr_address_o(addr), .dm_reg_rd_wr_data_io(bus),
    .DSP_reg_access_o(dsp)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [31:0] wdata;
  } acc_t;

  acc_t exp_q[$];

  // GPR file environment: answers reads, commits writes.
  logic [31:0] env_gpr [NGPR];
  assign bus = (en && !rw) ? env_gpr[addr[4:0]] : 32'bz;

  function automatic logic [31:0] gpr_init(int i);
    return (i == 4) ? 32'd9 : (32'hA500_0000 ^ (i * 32'h0103_0507));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every enabled access must match the next predicted one.
  initial begin
    acc_t a;
    for (int i = 0; i < NGPR; i++) env_gpr[i] = gpr_init(i);
    forever begin
      @(negedge clk);
      if (en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_access actual=addr %h rw %0d required=none", addr, rw);
        end else begin
          a = exp_q.pop_front();
          chk("acc_rw", 32'(rw), 32'(a.rw));
          chk("acc_addr", 32'(addr), 32'(a.addr));
          chk("acc_dsp", 32'(dsp), 32'd1);
          if (a.rw) chk("acc_wdata", bus, a.wdata);
        end
        if (rw) env_gpr[addr[4:0]] = bus;
      end
    end
  end

  // Reference model state
  logic [2:0]  m_err;
  logic [31:0] m_data0;
  logic [31:0] m_cmd;
  logic [31:0] ref_gpr [NGPR];
  int          busy_left;

  task automatic model_reset();
    m_err = 3'd0; m_data0 = 32'd0; m_cmd = 32'd0; busy_left = 0;
  endtask

  // One clock cycle: drive inputs, predict, advance.
  task automatic step(input logic cv, input logic [31:0] cmd, input logic ae,
                      input logic dw, input logic [31:0] wd, input logic [2:0] clr);
    logic [2:0] masked, ne;
    int regno, idx;
    bit bad, xfer;
    acc_t a;
    cmd_valid_i = cv; cmd_i = cmd; autoexec_i = ae;
    data0_wr_en_i = dw; data0_wdata_i = wd; cmderr_clr_i = clr;
    chk("busy", 32'(busy_o), 32'(busy_left > 0));
    masked = m_err & ~clr;
    ne = 3'd0;
    if (busy_left > 0) begin
      if (cv || ae || dw) ne = 3'd1;
      busy_left--;
    end else begin
      if (dw) m_data0 = wd;
      if ((cv || ae) && m_err == 3'd0) begin
        if (cv) m_cmd = cmd;
        regno = int'(m_cmd[15:0]);
        xfer  = m_cmd[17];
        bad = (m_cmd[31:24] != 8'd0) || m_cmd[18] ||
              (xfer && (m_cmd[22:20] != 3'd2 || regno < int'(BASE) || regno >= int'(BASE) + NGPR));
        if (bad) ne = 3'd2;
        else if (!halted_i) ne = 3'd4;
        else begin
          if (xfer) begin
            idx = regno - int'(BASE);
            a.rw = m_cmd[16]; a.addr = m_cmd[15:0];
            if (m_cmd[16]) begin
              a.wdata = m_data0; ref_gpr[idx] = m_data0;
            end else begin
              a.wdata = 32'd0; m_data0 = ref_gpr[idx];
            end
            exp_q.push_back(a);
            busy_left = 2;
          end else begin
            busy_left = 1;
          end
          if (m_cmd[19]) m_cmd[15:0] = m_cmd[15:0] + 16'd1;
        end
      end
    end
    m_err = (ne != 3'd0 && masked == 3'd0) ? ne : masked;
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0; autoexec_i = 1'b0; data0_wr_en_i = 1'b0; cmderr_clr_i = 3'd0;
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 3'd0);
  endtask

  task automatic drain_and_check();
    while (busy_left > 0) idle();
    idle();
    chk("cmderr", 32'(cmderr_o), 32'(m_err));
    chk("data0", data0_o, m_data0);
  endtask

  function automatic logic [31:0] rand_cmd();
    logic [31:0] c;
    int r;
    c = 32'd0;
    if ($urandom_range(0, 99) < 5) c[31:24] = 8'($urandom_range(1, 255));
    c[22:20] = ($urandom_range(0, 99) < 90) ? 3'd2 : 3'($urandom_range(0, 7));
    c[19] = ($urandom_range(0, 99) < 20);
    c[18] = ($urandom_range(0, 99) < 4);
    c[17] = ($urandom_range(0, 99) < 85);
    c[16] = $urandom_range(0, 1) == 1;
    r = $urandom_range(0, 99);
    if (r < 80)      c[15:0] = BASE + 16'($urandom_range(0, NGPR - 1));
    else if (r < 90) c[15:0] = BASE + 16'(NGPR - 1);
    else if (r < 94) c[15:0] = BASE - 16'd1;
    else if (r < 97) c[15:0] = BASE + 16'(NGPR);
    else             c[15:0] = 16'($urandom);
    return c;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    for (int i = 0; i < NGPR; i++) ref_gpr[i] = gpr_init(i);
    model_reset();
    // Reset values
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_cmderr", 32'(cmderr_o), 32'd0);
    chk("rst_data0", data0_o, 32'd0);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_dsp", 32'(dsp), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);

    // Read x4
    step(1'b1, 32'h0022_1004, 1'b0, 1'b0, 32'd0, 3'd0);
    chk("rd_en", 32'(en), 32'd1);
    chk("rd_rw", 32'(rw), 32'd0);
    chk("rd_addr", 32'(addr), 32'h1004);
    idle();
    chk("rd_data0", data0_o, 32'd9);
    idle();
    chk("rd_busy_end", 32'(busy_o), 32'd0);
    chk("rd_cmderr", 32'(cmderr_o), 32'd0);

    // Reset during ACCESS
    step(1'b1, 32'h0022_1004, 1'b0, 1'b0, 32'd0, 3'd0);
    rst_i = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst_i = 1'b0;
    model_reset();
    chk("mid_rst_en", 32'(en), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_data0", data0_o, 32'd0);

    // Write x5
    step(1'b0, 32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF, 3'd0);
    step(1'b1, 32'h0023_1005, 1'b0, 1'b0, 32'd0, 3'd0);
    chk("wr_rw", 32'(rw), 32'd1);
    chk("wr_bus", bus, 32'hDEAD_BEEF);
    drain_and_check();

    // Unsupported, ignored while error pending, then cleared and retried
    step(1'b1, 32'h0032_1004, 1'b0, 1'b0, 32'd0, 3'd0);
    chk("nosup_en", 32'(en), 32'd0);
    chk("nosup_err", 32'(cmderr_o), 32'd2);
    step(1'b1, 32'h0022_1004, 1'b0, 1'b0, 32'd0, 3'd0);
    chk("ignored_en", 32'(en), 32'd0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 3'b111);
    step(1'b1, 32'h0022_1004, 1'b0, 1'b0, 32'd0, 3'd0);
    chk("retry_en", 32'(en), 32'd1);
    drain_and_check();

    // Busy collision
    step(1'b1, 32'h0022_1004, 1'b0, 1'b0, 32'd0, 3'd0);
    step(1'b1, 32'h0023_1005, 1'b0, 1'b0, 32'd0, 3'd0);
    drain_and_check();
    chk("busy_err", 32'(cmderr_o), 32'd1);
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 3'b111);

    // Not halted
    halted_i = 1'b0;
    step(1'b1, 32'h0022_1004, 1'b0, 1'b0, 32'd0, 3'd0);
    chk("halt_err", 32'(cmderr_o), 32'd4);
    halted_i = 1'b1;
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 3'b111);

    // Postincrement wrap past the last GPR
    step(1'b1, 32'h002A_101F, 1'b0, 1'b0, 32'd0, 3'd0);
    drain_and_check();
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 3'd0);
    chk("postinc_err", 32'(cmderr_o), 32'd2);
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 3'b111);
    drain_and_check();

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 99);
      if (r < 10) step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 3'($urandom_range(0, 7)));
      else if (r < 15) begin
        halted_i = ($urandom_range(0, 3) != 0);
        idle();
      end else if (r < 30)
        step($urandom_range(0, 1) == 1, rand_cmd(), 1'b0, 1'b1, $urandom, 3'd0);
      else if (r < 45)
        step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 3'd0);
      else
        step(1'b1, rand_cmd(), 1'b0, 1'b0, 32'd0, 3'd0);
      if (busy_left > 0 && $urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 2);
        step(r == 0, rand_cmd(), r == 1, r == 2, $urandom, 3'($urandom_range(0, 7)));
      end
      drain_and_check();
      if (m_err != 3'd0 && $urandom_range(0, 1) == 1)
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 3'b111);
    end
    drain_and_check();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
